// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receiver: deframer states, prefix bytes and
// the layout of one queued scan-code entry.
package ps2_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StData,
      StPar,
      StStop
   } ps2_state_e;

   localparam logic [7:0] PS2_PFX_EXT = 8'hE0;
   localparam logic [7:0] PS2_PFX_BRK = 8'hF0;

   localparam int unsigned PS2_ENTRY_W        = 10;
   localparam int unsigned PS2_ENTRY_CODE_LSB = 0;
   localparam int unsigned PS2_ENTRY_BRK      = 8;
   localparam int unsigned PS2_ENTRY_EXT      = 9;

   typedef struct packed {
      logic       ext;
      logic       brk;
      logic [7:0] code;
   } ps2_entry_t;

   // Odd parity: data bits plus parity bit must contain an odd number of ones.
   function automatic logic ps2_parity_ok(input logic [7:0] data, input logic par);
      return ^{data, par};
   endfunction

endpackage

// File: rtl/ps2_code_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO is accepted only when a pop
// happens in the same cycle.
module ps2_code_fifo #(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned WIDTH = 10
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] pop_data,
   output logic             full,
   output logic             empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      count_q, count_d;
   logic             push_ok, pop_ok;

   assign empty    = (count_q == '0);
   assign full     = (count_q == FULL_CNT);
   assign pop_ok   = pop & ~empty;
   assign push_ok  = push & (~full | pop_ok);
   assign pop_data = mem_q[rd_ptr_q];

   always_comb begin
      count_d = count_q;
      unique case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Storage is reset too so the show-ahead head never presents X while empty.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
            wr_ptr_q        <= wr_ptr_q + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_q <= rd_ptr_q + 1'b1;
         end
         count_q <= count_d;
      end
   end

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchronizes the pins, deframes 11-bit frames, folds the E0/F0
// prefixes into flag bits and queues each completed code for a valid/ready consumer.
module ps2_rx_fifo
   import ps2_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH  = 8,
   parameter int unsigned TIMEOUT_CYC = 100000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic       code_valid,
   input  logic       code_ready,
   output logic [7:0] code,
   output logic       code_brk,
   output logic       code_ext,
   output logic       frame_err,
   output logic       overflow,
   input  logic       err_clr
);

   localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

   logic          clk_sync1_q, clk_sync2_q, clk_prev_q;
   logic          dat_sync1_q, dat_sync2_q;
   logic          fall, bit_in;

   ps2_state_e    state_q, state_d;
   logic [2:0]    bit_cnt_q, bit_cnt_d;
   logic [7:0]    shift_q, shift_d;
   logic          par_q, par_d;
   logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
   logic          tmo_hit;
   logic          pend_ext_q, pend_ext_d;
   logic          pend_brk_q, pend_brk_d;
   logic          frame_err_q, err_d;
   logic          overflow_q, overflow_d;

   logic          push, pop, fifo_full, fifo_empty, drop;
   ps2_entry_t    push_entry;
   logic [PS2_ENTRY_W-1:0] head;

   // Synchronizers idle high so reset never fakes a falling edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_sync1_q <= 1'b1;
         clk_sync2_q <= 1'b1;
         clk_prev_q  <= 1'b1;
         dat_sync1_q <= 1'b1;
         dat_sync2_q <= 1'b1;
      end else begin
         clk_sync1_q <= ps2_clk;
         clk_sync2_q <= clk_sync1_q;
         clk_prev_q  <= clk_sync2_q;
         dat_sync1_q <= ps2_data;
         dat_sync2_q <= dat_sync1_q;
      end
   end

   assign fall    = clk_prev_q & ~clk_sync2_q;
   assign bit_in  = dat_sync2_q;
   assign tmo_hit = (tmo_cnt_q == TMO_LAST);

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      par_d      = par_q;
      tmo_cnt_d  = tmo_cnt_q;
      pend_ext_d = pend_ext_q;
      pend_brk_d = pend_brk_q;
      err_d      = 1'b0;
      push       = 1'b0;
      push_entry = '{ext: pend_ext_q, brk: pend_brk_q, code: shift_q};

      unique case (state_q)
         StIdle: begin
            if (fall && !bit_in) begin
               state_d   = StData;
               bit_cnt_d = '0;
            end
         end
         StData: begin
            if (fall) begin
               shift_d   = {bit_in, shift_q[7:1]};
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  state_d = StPar;
               end
            end
         end
         StPar: begin
            if (fall) begin
               par_d   = bit_in;
               state_d = StStop;
            end
         end
         StStop: begin
            if (fall) begin
               state_d = StIdle;
               if (ps2_parity_ok(shift_q, par_q) && bit_in) begin
                  if (shift_q == PS2_PFX_EXT) begin
                     pend_ext_d = 1'b1;
                  end else if (shift_q == PS2_PFX_BRK) begin
                     pend_brk_d = 1'b1;
                  end else begin
                     push       = 1'b1;
                     pend_ext_d = 1'b0;
                     pend_brk_d = 1'b0;
                  end
               end else begin
                  err_d      = 1'b1;
                  pend_ext_d = 1'b0;
                  pend_brk_d = 1'b0;
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Idle watchdog: only an in-progress frame can time out; any fall rearms it.
      if (state_q == StIdle || fall) begin
         tmo_cnt_d = '0;
      end else if (tmo_hit) begin
         tmo_cnt_d  = '0;
         state_d    = StIdle;
         err_d      = 1'b1;
         pend_ext_d = 1'b0;
         pend_brk_d = 1'b0;
      end else begin
         tmo_cnt_d = tmo_cnt_q + 1'b1;
      end
   end

   assign pop        = code_valid & code_ready;
   assign drop       = push & fifo_full & ~pop;
   assign overflow_d = drop ? 1'b1 : (err_clr ? 1'b0 : overflow_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         bit_cnt_q   <= '0;
         shift_q     <= '0;
         par_q       <= 1'b0;
         tmo_cnt_q   <= '0;
         pend_ext_q  <= 1'b0;
         pend_brk_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         bit_cnt_q   <= bit_cnt_d;
         shift_q     <= shift_d;
         par_q       <= par_d;
         tmo_cnt_q   <= tmo_cnt_d;
         pend_ext_q  <= pend_ext_d;
         pend_brk_q  <= pend_brk_d;
         frame_err_q <= err_d;
         overflow_q  <= overflow_d;
      end
   end

   ps2_code_fifo #(
      .DEPTH(FIFO_DEPTH),
      .WIDTH(PS2_ENTRY_W)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .push_data (push_entry),
      .pop       (pop),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign code_valid = ~fifo_empty;
   assign code       = head[PS2_ENTRY_CODE_LSB +: 8];
   assign code_brk   = head[PS2_ENTRY_BRK];
   assign code_ext   = head[PS2_ENTRY_EXT];
   assign frame_err  = frame_err_q;
   assign overflow   = overflow_q;

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

PS/2 keyboard receiver with a prefix-folding scan-code FIFO. It samples the raw PS/2 clock/data pins, deframes 11-bit frames, and folds the 0xE0 (extended) and 0xF0 (break) prefixes into flag bits. Each completed code is queued and presented over a valid/ready interface. It sits directly upstream of the keyboard scan-code lookup stage, whose key-match mux consumes `code` as its selection key.

## Interface
- `FIFO_DEPTH`, 8: queue entries; power of two, ≥2.
- `TIMEOUT_CYC`, 100000: clk cycles without a PS/2 falling edge before an in-progress frame is aborted.

- `clk` in 1: system clock.
- `rst_n` in 1: reset; asynchronous, active-low.
- `ps2_clk` in 1: raw PS/2 clock pin (asynchronous).
- `ps2_data` in 1: raw PS/2 data pin (asynchronous).
- `code_valid` out 1: FIFO head valid.
- `code_ready` in 1: consumer accepts head.
- `code` out 8: head scan code (prefixes removed).
- `code_brk` out 1: head code was preceded by 0xF0 (key release).
- `code_ext` out 1: head code was preceded by 0xE0.
- `frame_err` out 1: one-cycle pulse on a dropped frame (parity, stop, or timeout).
- `overflow` out 1: sticky; set when a code is dropped because the FIFO is full.
- `err_clr` in 1: synchronous clear of `overflow`.

## Operation
- Input conditioning: both pins pass through 2-flop synchronizers. A third flop holds the previous synchronized clock. `fall = prev & ~sync_clk`.
- Frame format: start bit 0, data[0..7] LSB first, odd parity, stop bit 1. One bit is sampled from synchronized data on each `fall`.
- FSM states and transitions:
  - IDLE: on `fall` with data=0 → DATA, bit count=0. On `fall` with data=1, stay in IDLE; this is not an error.
  - DATA: shift the sampled bit in at bit 7 and shift right. After the 8th bit → PAR.
  - PAR: latch the parity bit → STOP.
  - STOP: on `fall`, evaluate the frame, then → IDLE.
  - Timeout: in DATA/PAR/STOP, the idle counter reaches `TIMEOUT_CYC` → IDLE, pulse `frame_err`, clear prefix flags. The counter resets on every `fall` and in IDLE.
- Frame good when XOR(data, parity)=1 and stop=1. Otherwise drop the byte, pulse `frame_err`, and clear `pend_ext`/`pend_brk`.
- Good byte handling:
  - 0xE0 → set `pend_ext`; no push.
  - 0xF0 → set `pend_brk`; no push.
  - Any other byte → push {pend_ext, pend_brk, byte}, then clear both flags.
- FIFO: entry = 10 bits. Show-ahead: the head is always driven on `code`/`code_brk`/`code_ext`. A pop occurs when `code_valid & code_ready`.
- Push while full with no pop → entry dropped, `overflow` set. Push while full with a pop in the same cycle → accepted, count unchanged.
- Push while empty → the entry is visible the next cycle; there is no bypass.
- `err_clr` and a new overflow in the same cycle → `overflow` stays 1 (set wins).
- Output values while empty: `code`/`code_brk`/`code_ext` are don't-care, and must be stable with no X after reset.

## Timing
- Reset values:
  - `code_valid`=0, `code`=0, `code_brk`=0, `code_ext`=0, `frame_err`=0, `overflow`=0.
  - FSM in IDLE; pointers, count, prefix flags, and timeout counter all 0.
  - Synchronizers reset to 1 (bus idle).
- Edge detection: a pin falling edge is detected at the 2nd rising clk edge after it. The FSM consumes the detection at the 3rd rising clk edge.
- Stop-bit `fall` → push at the same 3rd edge → `code_valid`=1 from that edge, when the FIFO was empty.
- `frame_err` is high for exactly one cycle, starting at that same 3rd edge, or at the timeout edge.
- Throughput: one pop per cycle. Independent of PS/2 rate.
- Reset mid-frame: the partial frame is discarded and the FIFO is emptied immediately (asynchronous).
- Assumes the PS/2 clock low and high phases are each ≥3 clk cycles.

## Structure
- Package `ps2_pkg`:
  - FSM state enum (IDLE, DATA, PAR, STOP).
  - `PS2_PFX_EXT`=8'hE0, `PS2_PFX_BRK`=8'hF0.
  - Entry width constant (10) and entry field offsets.
- Sub-module `ps2_code_fifo`: parameterized synchronous FIFO with show-ahead read, full/empty flags, and push-on-full-with-pop behaviour. The deframer, the prefix fold, and the flags stay in the top level.

## Test plan
- Key press: frame 0x1C (parity 0) → one entry, `code`=0x1C, `brk`=0, `ext`=0; `code_valid` 3 clk cycles after the stop-bit falling edge.
- Extended release: frames E0, F0, 75 → single entry `code`=0x75, `ext`=1, `brk`=1; no entries for the prefixes.
- Bad parity on 0x1C, then a good 0x32 → one `frame_err` pulse, only 0x32 queued; the prefix state was cleared by the error.
- Overflow: 9 codes with `code_ready`=0 (depth 8) → 8 entries in order, `overflow`=1, the 9th dropped. `err_clr` clears `overflow`; drain returns the first 8 codes.
- Timeout: stop the PS/2 clock after 4 data bits for `TIMEOUT_CYC` cycles → `frame_err` pulse, FSM back in IDLE, the next full frame 0x1C is received correctly.
- Reset asserted mid-frame with 3 entries queued → `code_valid`=0 immediately; the next frame is received normally after release.
